// File: rtl/bram_rr_arbiter.sv
// bram_rr_arbiter
// Shares one simple-dual-port BRAM (one write port, one registered read port)
// between two requesters A and B. Write and read ports are arbitrated
// independently with round-robin priority. A tag pipeline that matches the BRAM
// read latency steers each read result back to the requester that issued it.
// Reset is asynchronous. Its deassertion must be synchronized outside this block.

module bram_rr_arbiter #(
    parameter  int N_ADDR     = 256,
    parameter  int DATA_WIDTH = 16,
    parameter  int READ_LAT   = 1,
    localparam int AW         = $clog2(N_ADDR)
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  a_wvalid,
    input  logic [AW-1:0]         a_wadd,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_wready,
    input  logic                  a_rvalid,
    input  logic [AW-1:0]         a_radd,
    output logic                  a_rready,
    output logic                  a_dvalid,
    output logic [DATA_WIDTH-1:0] a_dout,

    input  logic                  b_wvalid,
    input  logic [AW-1:0]         b_wadd,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_wready,
    input  logic                  b_rvalid,
    input  logic [AW-1:0]         b_radd,
    output logic                  b_rready,
    output logic                  b_dvalid,
    output logic [DATA_WIDTH-1:0] b_dout,

    output logic                  bram_wen,
    output logic [AW-1:0]         bram_wadd,
    output logic [DATA_WIDTH-1:0] bram_win,
    output logic                  bram_ren,
    output logic [AW-1:0]         bram_radd,
    input  logic [DATA_WIDTH-1:0] bram_wout
);

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_t;

    // Requester granted most recently on each port. On contention the other one wins.
    req_t w_last;
    req_t r_last;

    logic w_gnt_a;
    logic w_gnt_b;
    logic r_gnt_a;
    logic r_gnt_b;

    // Tag pipeline, one stage per cycle of BRAM read latency: valid and "is B".
    logic [READ_LAT-1:0] tag_v;
    logic [READ_LAT-1:0] tag_b;
    logic                ret_v;
    logic                ret_b;

    // Write-port grant: a lone requester wins, contention goes to the one not served last.
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (!rst) begin
            if (a_wvalid && b_wvalid) begin
                if (w_last == REQ_B) begin
                    w_gnt_a = 1'b1;
                end else begin
                    w_gnt_b = 1'b1;
                end
            end else begin
                w_gnt_a = a_wvalid;
                w_gnt_b = b_wvalid;
            end
        end
    end

    // Read-port grant: same policy as writes, with its own history.
    always_comb begin
        r_gnt_a = 1'b0;
        r_gnt_b = 1'b0;
        if (!rst) begin
            if (a_rvalid && b_rvalid) begin
                if (r_last == REQ_B) begin
                    r_gnt_a = 1'b1;
                end else begin
                    r_gnt_b = 1'b1;
                end
            end else begin
                r_gnt_a = a_rvalid;
                r_gnt_b = b_rvalid;
            end
        end
    end

    assign a_wready = w_gnt_a;
    assign b_wready = w_gnt_b;
    assign a_rready = r_gnt_a;
    assign b_rready = r_gnt_b;

    // BRAM port drive: the granted requester's fields, or A's when the port is idle.
    always_comb begin
        bram_wen  = w_gnt_a | w_gnt_b;
        bram_wadd = w_gnt_b ? b_wadd  : a_wadd;
        bram_win  = w_gnt_b ? b_wdata : a_wdata;
        bram_ren  = r_gnt_a | r_gnt_b;
        bram_radd = r_gnt_b ? b_radd  : a_radd;
    end

    // Round-robin history. Reset to B so that A wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_last <= REQ_B;
            r_last <= REQ_B;
        end else begin
            if (w_gnt_a) begin
                w_last <= REQ_A;
            end else if (w_gnt_b) begin
                w_last <= REQ_B;
            end
            if (r_gnt_a) begin
                r_last <= REQ_A;
            end else if (r_gnt_b) begin
                r_last <= REQ_B;
            end
        end
    end

    // Tag pipeline tracking in-flight reads. Reset drops them, so they never return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v <= '0;
            tag_b <= '0;
        end else begin
            tag_v[0] <= r_gnt_a | r_gnt_b;
            tag_b[0] <= r_gnt_b;
            for (int i = 1; i < READ_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_b[i] <= tag_b[i-1];
            end
        end
    end

    assign ret_v = tag_v[READ_LAT-1];
    assign ret_b = tag_b[READ_LAT-1];

    // Return registers: capture BRAM data for the tagged requester. dout holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_dvalid <= 1'b0;
            b_dvalid <= 1'b0;
            a_dout   <= '0;
            b_dout   <= '0;
        end else begin
            a_dvalid <= ret_v & ~ret_b;
            b_dvalid <= ret_v &  ret_b;
            if (ret_v && !ret_b) begin
                a_dout <= bram_wout;
            end
            if (ret_v && ret_b) begin
                b_dout <= bram_wout;
            end
        end
    end

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Testbench for bram_rr_arbiter: behavioural BRAM, directed scenarios, and a
// randomized run checked against a reference model.

module tb_bram_rr_arbiter;

    localparam int N_ADDR = 256;
    localparam int DW     = 16;
    localparam int RL     = 1;
    localparam int AW     = 8;

    logic          clk;
    logic          rst;
    logic          a_wvalid, b_wvalid, a_rvalid, b_rvalid;
    logic [AW-1:0] a_wadd, b_wadd, a_radd, b_radd;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_wready, b_wready, a_rready, b_rready;
    logic          a_dvalid, b_dvalid;
    logic [DW-1:0] a_dout, b_dout;
    logic          bram_wen, bram_ren;
    logic [AW-1:0] bram_wadd, bram_radd;
    logic [DW-1:0] bram_win, bram_wout;

    int n_cmp = 0;
    int n_bad = 0;
    logic mem_load;

    bram_rr_arbiter #(.N_ADDR(N_ADDR), .DATA_WIDTH(DW), .READ_LAT(RL)) dut (
        .clk(clk), .rst(rst),
        .a_wvalid(a_wvalid), .a_wadd(a_wadd), .a_wdata(a_wdata), .a_wready(a_wready),
        .a_rvalid(a_rvalid), .a_radd(a_radd), .a_rready(a_rready),
        .a_dvalid(a_dvalid), .a_dout(a_dout),
        .b_wvalid(b_wvalid), .b_wadd(b_wadd), .b_wdata(b_wdata), .b_wready(b_wready),
        .b_rvalid(b_rvalid), .b_radd(b_radd), .b_rready(b_rready),
        .b_dvalid(b_dvalid), .b_dout(b_dout),
        .bram_wen(bram_wen), .bram_wadd(bram_wadd), .bram_win(bram_win),
        .bram_ren(bram_ren), .bram_radd(bram_radd), .bram_wout(bram_wout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return {a ^ 8'h5A, a};
    endfunction

    // Behavioural BRAM: registered, read-before-write, RL-cycle read latency.
    logic [DW-1:0] mem [N_ADDR];
    logic [DW-1:0] rd_pipe [RL];
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < N_ADDR; i++) mem[i] <= init_val(AW'(i));
        end else if (bram_wen) begin
            mem[bram_wadd] <= bram_win;
        end
        if (bram_ren) rd_pipe[0] <= mem[bram_radd];
        for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign bram_wout = rd_pipe[RL-1];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        a_wvalid = 0; b_wvalid = 0; a_rvalid = 0; b_rvalid = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Issues one read and reports the acceptance-to-dvalid latency (-1 if none).
    task automatic issue_read(input bit is_b, input logic [AW-1:0] addr,
                              output int lat, output logic [DW-1:0] data, output int other);
        bit got = 0;
        lat = -1; data = '0; other = 0;
        if (is_b) begin b_rvalid = 1; b_radd = addr; end
        else      begin a_rvalid = 1; a_radd = addr; end
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            got = is_b ? b_rready : a_rready;
            @(posedge clk); #1;
        end
        a_rvalid = 0; b_rvalid = 0;
        if (got) begin
            for (int k = 1; k <= 10 && lat < 0; k++) begin
                @(negedge clk);
                if (is_b ? a_dvalid : b_dvalid) other++;
                if (is_b ? b_dvalid : a_dvalid) begin
                    lat = k;
                    data = is_b ? b_dout : a_dout;
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic issue_write(input bit is_b, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data, output bit ok);
        ok = 0;
        if (is_b) begin b_wvalid = 1; b_wadd = addr; b_wdata = data; end
        else      begin a_wvalid = 1; a_wadd = addr; a_wdata = data; end
        for (int n = 0; n < 10 && !ok; n++) begin
            @(negedge clk);
            ok = is_b ? b_wready : a_wready;
            @(posedge clk); #1;
        end
        a_wvalid = 0; b_wvalid = 0;
    endtask

    task automatic test_reset();
        rst = 1; mem_load = 1;
        a_wvalid = 1; b_wvalid = 1; a_rvalid = 1; b_rvalid = 1;
        a_wadd = 0; b_wadd = 0; a_radd = 0; b_radd = 0; a_wdata = 0; b_wdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({a_wready, b_wready, a_rready, b_rready, bram_wen, bram_ren} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_ready: got %b expected 000000",
                     {a_wready, b_wready, a_rready, b_rready, bram_wen, bram_ren});
        end
        n_cmp++;
        if ({a_dvalid, b_dvalid, a_dout, b_dout} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got dvalid %b%b dout %h %h expected all zero",
                     a_dvalid, b_dvalid, a_dout, b_dout);
        end
        @(posedge clk); #1;
        mem_load = 0; rst = 0;
        idle_inputs();
    endtask

    task automatic test_write_read();
        int lat, oth;
        logic [DW-1:0] d;
        apply_reset();
        a_wvalid = 1; a_wadd = 8'h10; a_wdata = 16'h1234;
        @(negedge clk);
        n_cmp++;
        if ({a_wready, b_wready, bram_wen, bram_wadd, bram_win} !== {3'b101, 8'h10, 16'h1234}) begin
            n_bad++;
            $display("FAIL wr_grant: got rdy %b%b wen %b @%h=%h expected 10 1 @10=1234",
                     a_wready, b_wready, bram_wen, bram_wadd, bram_win);
        end
        @(posedge clk); #1;
        a_wvalid = 0;
        issue_read(0, 8'h10, lat, d, oth);
        n_cmp++;
        if (lat !== RL + 1) begin
            n_bad++; $display("FAIL rd_latency: got %0d expected %0d", lat, RL + 1);
        end
        n_cmp++;
        if (d !== 16'h1234) begin
            n_bad++; $display("FAIL rd_data: got %h expected 1234", d);
        end
        n_cmp++;
        if (oth !== 0) begin
            n_bad++; $display("FAIL rd_other_dvalid: got %0d expected 0", oth);
        end
        @(negedge clk);
        n_cmp++;
        if ({a_dvalid, b_dvalid} !== 2'b00 || a_dout !== 16'h1234) begin
            n_bad++;
            $display("FAIL rd_one_cycle: got dvalid %b%b dout %h expected 00 1234",
                     a_dvalid, b_dvalid, a_dout);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_alternating_reads();
        logic [AW-1:0] ac = 0, bc = 0, ex_addr;
        bit ea, eb, dva;
        int j;
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            a_rvalid = (c < 6); b_rvalid = (c < 6);
            a_radd = ac; b_radd = 8'h80 + bc;
            @(negedge clk);
            ea = (c < 6) && (c % 2 == 0);
            eb = (c < 6) && (c % 2 == 1);
            n_cmp++;
            if ({a_rready, b_rready} !== {ea, eb}) begin
                n_bad++;
                $display("FAIL alt_grant c%0d: got %b%b expected %b%b", c, a_rready, b_rready, ea, eb);
            end
            if (ea || eb) begin
                n_cmp++;
                if (bram_radd !== (ea ? ac : 8'h80 + bc)) begin
                    n_bad++;
                    $display("FAIL alt_radd c%0d: got %h expected %h", c, bram_radd, ea ? ac : 8'h80 + bc);
                end
            end
            if (c >= RL + 1 && c - (RL + 1) < 6) begin
                j = c - (RL + 1);
                dva = (j % 2 == 0);
                ex_addr = dva ? AW'(j / 2) : 8'h80 + AW'(j / 2);
                n_cmp++;
                if ({a_dvalid, b_dvalid} !== {dva, !dva} ||
                    (dva ? a_dout : b_dout) !== init_val(ex_addr)) begin
                    n_bad++;
                    $display("FAIL alt_return c%0d: got dvalid %b%b dout %h/%h expected %b%b data %h",
                             c, a_dvalid, b_dvalid, a_dout, b_dout, dva, !dva, init_val(ex_addr));
                end
            end else begin
                n_cmp++;
                if ({a_dvalid, b_dvalid} !== 2'b00) begin
                    n_bad++;
                    $display("FAIL alt_idle c%0d: got dvalid %b%b expected 00", c, a_dvalid, b_dvalid);
                end
            end
            if (ea) ac++;
            if (eb) bc++;
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic test_write_contention();
        int lat, oth;
        logic [DW-1:0] d;
        apply_reset();
        a_wvalid = 1; a_wadd = 8'h05; a_wdata = 16'hAAAA;
        b_wvalid = 1; b_wadd = 8'h05; b_wdata = 16'hBBBB;
        @(negedge clk);
        n_cmp++;
        if ({a_wready, b_wready, bram_win} !== {2'b10, 16'hAAAA}) begin
            n_bad++;
            $display("FAIL wc_first: got rdy %b%b win %h expected 10 AAAA", a_wready, b_wready, bram_win);
        end
        @(posedge clk); #1;
        a_wvalid = 0;
        @(negedge clk);
        n_cmp++;
        if ({a_wready, b_wready, bram_win} !== {2'b01, 16'hBBBB}) begin
            n_bad++;
            $display("FAIL wc_second: got rdy %b%b win %h expected 01 BBBB", a_wready, b_wready, bram_win);
        end
        @(posedge clk); #1;
        b_wvalid = 0;
        issue_read(0, 8'h05, lat, d, oth);
        n_cmp++;
        if (lat !== RL + 1 || d !== 16'hBBBB) begin
            n_bad++; $display("FAIL wc_readback: got lat %0d data %h expected %0d BBBB", lat, d, RL + 1);
        end
    endtask

    task automatic test_read_before_write();
        bit ok;
        int lat, oth;
        logic [DW-1:0] d;
        apply_reset();
        issue_write(0, 8'h20, 16'h1111, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL rbw_init_write: got no accept expected accept");
        end
        a_wvalid = 1; a_wadd = 8'h20; a_wdata = 16'h5555;
        b_rvalid = 1; b_radd = 8'h20;
        @(negedge clk);
        n_cmp++;
        if ({a_wready, b_rready} !== 2'b11) begin
            n_bad++; $display("FAIL rbw_grants: got %b%b expected 11", a_wready, b_rready);
        end
        @(posedge clk); #1;
        idle_inputs();
        lat = -1; d = '0;
        for (int k = 1; k <= 10 && lat < 0; k++) begin
            @(negedge clk);
            if (b_dvalid) begin lat = k; d = b_dout; end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (lat !== RL + 1 || d !== 16'h1111) begin
            n_bad++; $display("FAIL rbw_old_data: got lat %0d data %h expected %0d 1111", lat, d, RL + 1);
        end
        issue_read(1, 8'h20, lat, d, oth);
        n_cmp++;
        if (d !== 16'h5555) begin
            n_bad++; $display("FAIL rbw_new_data: got %h expected 5555", d);
        end
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        b_rvalid = 1; b_radd = 8'h81;
        @(negedge clk);
        n_cmp++;
        if (b_rready !== 1'b1) begin
            n_bad++; $display("FAIL mid_accept_b: got %b expected 1", b_rready);
        end
        @(posedge clk); #1;
        b_rvalid = 0;
        a_rvalid = 1; a_radd = 8'h01;
        a_wvalid = 1; a_wadd = 8'h30; a_wdata = 16'h7777;
        @(negedge clk);
        n_cmp++;
        if ({a_rready, a_wready} !== 2'b11) begin
            n_bad++; $display("FAIL mid_accept_a: got %b%b expected 11", a_rready, a_wready);
        end
        @(posedge clk); #1;
        rst = 1;
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({a_dvalid, b_dvalid} !== 2'b00) begin
                n_bad++; $display("FAIL mid_no_dvalid c%0d: got %b%b expected 00", i, a_dvalid, b_dvalid);
            end
            @(posedge clk); #1;
            if (i == 1) rst = 0;
        end
        a_rvalid = 1; b_rvalid = 1; a_wvalid = 1; b_wvalid = 1;
        a_radd = 8'h02; b_radd = 8'h82; b_wadd = 8'h31; b_wdata = 16'h8888;
        @(negedge clk);
        n_cmp++;
        if ({a_rready, b_rready, a_wready, b_wready} !== 4'b1010) begin
            n_bad++;
            $display("FAIL mid_rr_restart: got %b expected 1010", {a_rready, b_rready, a_wready, b_wready});
        end
        @(posedge clk); #1;
        idle_inputs();
        repeat (RL + 2) @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [DW-1:0] ref_mem [16];
        bit            slot_v [8];
        bit            slot_b [8];
        logic [DW-1:0] slot_d [8];
        bit lw, lr, gwa, gwb, gra, grb, eav, ebv;
        logic [DW-1:0] hold_a, hold_b;
        logic [AW-1:0] ra;
        int s;
        apply_reset();
        lw = 1; lr = 1; hold_a = '0; hold_b = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_val(8'hC0 | AW'(i));
        for (int i = 0; i < 8; i++) begin slot_v[i] = 0; slot_b[i] = 0; slot_d[i] = '0; end
        for (int t = 0; t < 300; t++) begin
            if (!a_wvalid && $urandom_range(0, 2) != 0) begin
                a_wvalid = 1; a_wadd = 8'hC0 | AW'($urandom_range(0, 15)); a_wdata = DW'($urandom);
            end
            if (!b_wvalid && $urandom_range(0, 2) != 0) begin
                b_wvalid = 1; b_wadd = 8'hC0 | AW'($urandom_range(0, 15)); b_wdata = DW'($urandom);
            end
            if (!a_rvalid && $urandom_range(0, 2) != 0) begin
                a_rvalid = 1; a_radd = 8'hC0 | AW'($urandom_range(0, 15));
            end
            if (!b_rvalid && $urandom_range(0, 2) != 0) begin
                b_rvalid = 1; b_radd = 8'hC0 | AW'($urandom_range(0, 15));
            end
            @(negedge clk);
            // Rule: lone requester wins; on contention, whoever was not served last.
            if (a_wvalid && b_wvalid) begin gwa = lw; gwb = !lw; end
            else begin gwa = a_wvalid; gwb = b_wvalid; end
            if (a_rvalid && b_rvalid) begin gra = lr; grb = !lr; end
            else begin gra = a_rvalid; grb = b_rvalid; end
            n_cmp++;
            if ({a_wready, b_wready, a_rready, b_rready, bram_wen, bram_ren} !==
                {gwa, gwb, gra, grb, gwa | gwb, gra | grb}) begin
                n_bad++;
                $display("FAIL rnd_grant t%0d: got %b expected %b", t,
                         {a_wready, b_wready, a_rready, b_rready, bram_wen, bram_ren},
                         {gwa, gwb, gra, grb, gwa | gwb, gra | grb});
            end
            if (gwa || gwb) begin
                n_cmp++;
                if ({bram_wadd, bram_win} !== (gwb ? {b_wadd, b_wdata} : {a_wadd, a_wdata})) begin
                    n_bad++;
                    $display("FAIL rnd_wport t%0d: got @%h=%h", t, bram_wadd, bram_win);
                end
            end
            if (gra || grb) begin
                ra = grb ? b_radd : a_radd;
                s = (t + RL + 1) % 8;
                slot_v[s] = 1; slot_b[s] = grb; slot_d[s] = ref_mem[ra[3:0]];
            end
            if (gwa) ref_mem[a_wadd[3:0]] = a_wdata;
            else if (gwb) ref_mem[b_wadd[3:0]] = b_wdata;
            if (gwa) lw = 0; else if (gwb) lw = 1;
            if (gra) lr = 0; else if (grb) lr = 1;
            s = t % 8;
            eav = slot_v[s] && !slot_b[s];
            ebv = slot_v[s] && slot_b[s];
            if (eav) hold_a = slot_d[s];
            if (ebv) hold_b = slot_d[s];
            slot_v[s] = 0;
            n_cmp++;
            if ({a_dvalid, b_dvalid} !== {eav, ebv} || {a_dout, b_dout} !== {hold_a, hold_b}) begin
                n_bad++;
                $display("FAIL rnd_return t%0d: got dvalid %b%b dout %h %h expected %b%b %h %h",
                         t, a_dvalid, b_dvalid, a_dout, b_dout, eav, ebv, hold_a, hold_b);
            end
            @(posedge clk); #1;
            if (gwa) a_wvalid = 0;
            if (gwb) b_wvalid = 0;
            if (gra) a_rvalid = 0;
            if (grb) b_rvalid = 0;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_alternating_reads();
        test_write_contention();
        test_read_before_write();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
